// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: round-robin frame builder for the 12-byte aligned link (2 header + 10 payload bytes).
// Latency: header LSB one cycle after the winning arbitration cycle; frames run back-to-back with no gap.
// Backpressure: sources hold req until granted; pl_ready strobes one payload byte per cycle from the owner.
//
// Ports:
//   clk, reset (async, active-high)
//   tx_en            - allow new frames to start
//   req, hdr_type    - per-source request and header select (0: AA/AF, 1: 55/BA)
//   pl_data          - per-source payload byte, slice i on [8i+7:8i]
//   pl_ready         - one-hot payload consume strobe
//   grant            - one-hot owner of the frame on tx_data
//   tx_data, tx_sof, tx_pos, busy, frame_done - registered link byte and its frame status
//
// Build option: define FILL_FRAME_EN to send a fill frame (AA AF + IDLE_BYTE payload) after
// FILL_GAP consecutive idle bytes, keeping the receiver aligned on a quiet link.
module frame_tx_scheduler #(
  parameter int         NUM_REQ     = 4,
  parameter int         PAYLOAD_LEN = 10,
  parameter logic [7:0] IDLE_BYTE   = 8'h00,
  parameter int         FILL_GAP    = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   hdr_type,
  input  logic [8*NUM_REQ-1:0] pl_data,
  output logic [NUM_REQ-1:0]   pl_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_sof,
  output logic [3:0]           tx_pos,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int         IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAST_POS = 4'(PAYLOAD_LEN + 1);
  localparam logic [7:0] HDR0_LSB = 8'hAA;
  localparam logic [7:0] HDR0_MSB = 8'hAF;
  localparam logic [7:0] HDR1_LSB = 8'h55;
  localparam logic [7:0] HDR1_MSB = 8'hBA;

  typedef enum logic [1:0] {IDLE, HLSB, HMSB, PAYLOAD} state_t;

  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic          typ, typ_nxt;     // header type latched at grant
  logic          fill, fill_nxt;   // current frame is a fill frame

  logic [NUM_REQ-1:0] rdy_nxt, grant_nxt;
  logic [7:0]         data_nxt;
  logic               sof_nxt, busy_nxt, done_nxt;
  logic [3:0]         pos_nxt;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          slot, start, fill_start;

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int k;
    k       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!win_vld && req[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end

  // The last payload byte cycle doubles as the next arbitration slot, giving gapless back-to-back frames.
  assign slot  = (state == IDLE) || frame_done;
  assign start = slot && tx_en && win_vld;

`ifdef FILL_FRAME_EN
  localparam int CW = $clog2(FILL_GAP + 1);
  logic [CW-1:0] idle_cnt;

  // Counts idle bytes already on the line; the current idle cycle is number idle_cnt+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state == IDLE) begin
      if (idle_cnt != CW'(FILL_GAP)) idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end

  assign fill_start = (state == IDLE) && !start && (idle_cnt >= CW'(FILL_GAP - 1));
`else
  // Without fill frames the idle byte repeats indefinitely; FILL_GAP has no effect in this build.
  assign fill_start = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;
    typ_nxt    = typ;
    fill_nxt   = fill;
    data_nxt   = IDLE_BYTE;
    sof_nxt    = 1'b0;
    pos_nxt    = 4'd0;
    busy_nxt   = 1'b0;
    grant_nxt  = '0;
    rdy_nxt    = '0;
    done_nxt   = 1'b0;

    if (slot) begin
      if (start) begin
        state_nxt  = HLSB;
        owner_nxt  = win_idx;
        typ_nxt    = hdr_type[win_idx];
        fill_nxt   = 1'b0;
        rr_ptr_nxt = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        grant_nxt[win_idx] = 1'b1;
        data_nxt   = hdr_type[win_idx] ? HDR1_LSB : HDR0_LSB;
        sof_nxt    = 1'b1;
        busy_nxt   = 1'b1;
      end else if (fill_start) begin
        // Fill frame: AA AF header, no owner, RR pointer untouched.
        state_nxt = HLSB;
        typ_nxt   = 1'b0;
        fill_nxt  = 1'b1;
        data_nxt  = HDR0_LSB;
        sof_nxt   = 1'b1;
        busy_nxt  = 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end else begin
      unique case (state)
        HLSB: begin
          state_nxt = HMSB;
          data_nxt  = typ ? HDR1_MSB : HDR0_MSB;
          pos_nxt   = 4'd1;
          busy_nxt  = 1'b1;
          grant_nxt = grant;
          rdy_nxt   = fill ? '0 : grant;
        end
        HMSB: begin
          // The byte consumed during the HMSB strobe becomes payload byte 0.
          state_nxt = PAYLOAD;
          data_nxt  = fill ? IDLE_BYTE : pl_data[8*int'(owner) +: 8];
          pos_nxt   = 4'd2;
          busy_nxt  = 1'b1;
          grant_nxt = grant;
          rdy_nxt   = fill ? '0 : grant;
        end
        PAYLOAD: begin
          state_nxt = PAYLOAD;
          data_nxt  = fill ? IDLE_BYTE : pl_data[8*int'(owner) +: 8];
          pos_nxt   = tx_pos + 4'd1;
          busy_nxt  = 1'b1;
          grant_nxt = grant;
          // Ten strobes total: HMSB plus the first nine payload cycles.
          rdy_nxt   = (fill || (pos_nxt == LAST_POS)) ? '0 : grant;
          done_nxt  = (pos_nxt == LAST_POS);
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      typ        <= 1'b0;
      fill       <= 1'b0;
      tx_data    <= IDLE_BYTE;
      tx_sof     <= 1'b0;
      tx_pos     <= 4'd0;
      busy       <= 1'b0;
      grant      <= '0;
      pl_ready   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner      <= owner_nxt;
      typ        <= typ_nxt;
      fill       <= fill_nxt;
      tx_data    <= data_nxt;
      tx_sof     <= sof_nxt;
      tx_pos     <= pos_nxt;
      busy       <= busy_nxt;
      grant      <= grant_nxt;
      pl_ready   <= rdy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: directed scoreboard bench for frame_tx_scheduler.
// Expected link bytes are queued when a frame is provoked and popped on every sampled cycle.
// Sources advance their payload counter after each observed pl_ready strobe.
module tb_frame_tx_scheduler;

  localparam int         N    = 4;
  localparam logic [7:0] IDLE = 8'h00;

  logic         clk = 1'b0;
  logic         reset;
  logic         tx_en;
  logic [N-1:0] req, hdr_type;
  logic [8*N-1:0] pl_data;
  logic [N-1:0] pl_ready, grant;
  logic [7:0]   tx_data;
  logic         tx_sof, busy, frame_done;
  logic [3:0]   tx_pos;

  frame_tx_scheduler dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .req(req), .hdr_type(hdr_type),
    .pl_data(pl_data), .pl_ready(pl_ready), .grant(grant), .tx_data(tx_data),
    .tx_sof(tx_sof), .tx_pos(tx_pos), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   data;
    logic [3:0]   pos;
    logic         sof;
    logic [N-1:0] gnt;
    logic [N-1:0] rdy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   src_cnt[N];   // what each source currently presents
  int   mdl_cnt[N];   // what the model expects each source to be asked for next
  logic [N-1:0] rdy_q = '0;

  function automatic logic [7:0] pl_byte(int i, int c);
    return 8'(i * 32 + (c % 32));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pl();
    for (int i = 0; i < N; i++) pl_data[8*i +: 8] = pl_byte(i, src_cnt[i]);
  endtask

  task automatic reset_sources();
    for (int i = 0; i < N; i++) begin
      src_cnt[i] = 1;
      mdl_cnt[i] = 1;
    end
    rdy_q = '0;
    drive_pl();
  endtask

  task automatic push_frame(int src, bit typ, bit is_fill);
    exp_t e;
    for (int p = 0; p < 12; p++) begin
      e.pos  = 4'(p);
      e.sof  = (p == 0);
      e.done = (p == 11);
      e.gnt  = is_fill ? '0 : N'(1 << src);
      e.rdy  = (!is_fill && p >= 1 && p <= 10) ? N'(1 << src) : '0;
      if (p == 0)      e.data = typ ? 8'h55 : 8'hAA;
      else if (p == 1) e.data = typ ? 8'hBA : 8'hAF;
      else if (is_fill) e.data = IDLE;
      else begin
        e.data = pl_byte(src, mdl_cnt[src]);
        mdl_cnt[src]++;
      end
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_data"},  tx_data, IDLE);
    chk({tag, "_sof"},   tx_sof, 0);
    chk({tag, "_pos"},   tx_pos, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_rdy"},   pl_ready, 0);
    chk({tag, "_done"},  frame_done, 0);
  endtask

  // Sample at the falling edge; an empty scoreboard means the link must be idle.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("busy",       busy, 1);
      chk("tx_data",    tx_data, e.data);
      chk("tx_pos",     tx_pos, e.pos);
      chk("tx_sof",     tx_sof, e.sof);
      chk("grant",      grant, e.gnt);
      chk("pl_ready",   pl_ready, e.rdy);
      chk("frame_done", frame_done, e.done);
    end else begin
      check_reset_outputs("idle");
    end
    rdy_q = pl_ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rdy_q[i]) src_cnt[i]++;
    drive_pl();
    sample();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    sample();
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_async");
    sb.delete();
    rdy_q = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    tx_en    = 1'b1;
    req      = '0;
    hdr_type = '0;
    pl_data  = '0;
    reset_sources();

    // Reset state, then first post-reset byte.
    sample();
    release_reset();

    // Single frame from source 0, type 0: AA AF 01..0A.
    req = 4'b0001;
    push_frame(0, 1'b0, 1'b0);
    step();
    req = '0;
    repeat (11) step();
    repeat (3) step();

    // Restart the RR pointer at 0 for the rotation test.
    apply_reset();
    sample();
    release_reset();

    // Round-robin with all sources requesting, type 1, back-to-back frames.
    hdr_type = 4'b1111;
    req      = 4'b1111;
    push_frame(0, 1'b1, 1'b0);
    push_frame(1, 1'b1, 1'b0);
    push_frame(2, 1'b1, 1'b0);
    push_frame(3, 1'b1, 1'b0);
    push_frame(0, 1'b1, 1'b0);
    repeat (48) step();
    step();
    req = '0;
    repeat (11) step();
    repeat (2) step();

    // Mid-frame drop of req and tx_en: frame completes, nothing follows.
    req = 4'b0010;
    push_frame(1, 1'b1, 1'b0);
    repeat (6) step();
    req   = '0;
    tx_en = 1'b0;
    repeat (6) step();
    req = 4'b0001;
    repeat (5) step();
    req   = '0;
    tx_en = 1'b1;
    step();

    // Reset at tx_pos 7 of a source-0 frame; afterwards source 2 wins first.
    hdr_type = '0;
    req      = 4'b0001;
    push_frame(0, 1'b0, 1'b0);
    step();
    req = '0;
    repeat (7) step();
    apply_reset();
    reset_sources();
    req = 4'b0100;
    release_reset();
    push_frame(2, 1'b0, 1'b0);
    step();
    req = '0;
    repeat (11) step();
    repeat (2) step();

    // Quiet link for 60 cycles after reset.
    apply_reset();
    sample();
    release_reset();
`ifdef FILL_FRAME_EN
    repeat (23) step();
    push_frame(0, 1'b0, 1'b1);
    repeat (12) step();
    repeat (24) step();
`else
    repeat (59) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_tx_scheduler.md
# frame_tx_scheduler

Transmit-side frame scheduler that builds the 12-byte aligned frame stream (2 header bytes + 10 payload bytes) consumed by the receive frame aligner. It arbitrates round-robin among NUM_REQ payload sources and grants the serial byte lane to one source per frame. Between frames it inserts a safe idle byte. It sits between the payload sources and the byte-serial link toward the aligner.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- PAYLOAD_LEN, 10: payload bytes per frame. Fixed by the link format; any other value is illegal.
- IDLE_BYTE, 8'h00: inter-frame fill byte. Must not equal 8'hAA or 8'h55.
- FILL_GAP, 24: idle-byte count that triggers a fill frame. Used only with FILL_FRAME_EN.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- tx_en  in  1  high allows new frames to start; low lets the current frame finish, then idles.
- req  in  NUM_REQ  per-source frame request, level; held until the source's grant bit rises.
- hdr_type  in  NUM_REQ  per-source header select, sampled at grant: 0 selects AA/AF, 1 selects 55/BA.
- pl_data  in  8*NUM_REQ  payload byte of source i on bits [8i+7:8i].
- pl_ready  out  NUM_REQ  one-hot strobe; source i's pl_data slice is consumed this cycle and must advance next cycle.
- grant  out  NUM_REQ  one-hot owner of the frame currently on tx_data; zero when idle.
- tx_data  out  8  link byte, registered.
- tx_sof  out  1  high while tx_data carries a header LSB byte.
- tx_pos  out  4  byte position in frame: 0..11; 0 when idle.
- busy  out  1  high while a frame byte is on tx_data.
- frame_done  out  1  one-cycle pulse while the last payload byte (tx_pos=11) is on tx_data.

## Operation
- FSM states: IDLE, HLSB, HMSB, PAYLOAD, all registered. Outputs describe the byte currently on tx_data.
- **IDLE:** tx_data=IDLE_BYTE, busy=0, grant=0.
- **Arbitration slot:** any cycle in IDLE, or the cycle with frame_done=1.
  - If tx_en=1 and req≠0, pick a winner round-robin.
  - Search starts at (last winner + 1) mod NUM_REQ; after reset it starts at index 0.
  - Latch the winner and its hdr_type; next state is HLSB.
  - Otherwise next state is IDLE.
- **HLSB:** tx_data = AA (type 0) or 55 (type 1); tx_sof=1; tx_pos=0; grant set.
- **HMSB:** tx_data = AF (type 0) or BA (type 1); tx_pos=1.
- **PAYLOAD:** tx_pos 2..11; tx_data = winner's pl_data slice registered from the previous cycle.
  - pl_ready[winner] is high in the HMSB cycle and the first 9 PAYLOAD cycles, for exactly 10 strobes.
- **Ownership:** once granted, a frame always completes. Deasserting req or tx_en mid-frame has no effect on that frame.
- **Withdrawn requests:** a source may drop req before grant; it is then not considered.
- Payload content is not checked. Header-lookalike bytes in the payload are the source's concern.

## Timing
- All outputs come from registers. Reset values: tx_data=IDLE_BYTE; tx_sof=0, tx_pos=0, busy=0, grant=0, pl_ready=0, frame_done=0; state IDLE; RR pointer 0.
- Start-up latency: if req wins in IDLE cycle N, the header LSB appears at N+1 and the MSB at N+2.
  - pl_ready is high N+2..N+11; payload is on tx_data N+3..N+12; frame_done at N+12.
- Back-to-back: if a request is pending in the frame_done cycle, the next header LSB follows in the very next cycle, with no idle gap.
- Reset asserted mid-frame truncates the frame immediately; the pending winner is lost. The first post-reset byte is IDLE_BYTE.
- The round-robin pointer updates only when a grant is issued.

## Configuration
- FILL_FRAME_EN defined:
  - An idle counter counts consecutive IDLE cycles and clears on any frame.
  - When it reaches FILL_GAP at an arbitration slot with no winner (req=0 or tx_en=0), the block sends a fill frame: AA AF header, 10 bytes of IDLE_BYTE, tx_sof and frame_done as normal, grant=0, pl_ready=0.
  - The RR pointer is unchanged by fill frames.
  - Purpose: keep the receiver's not-aligned byte count below 47.
- FILL_FRAME_EN undefined: IDLE_BYTE is sent indefinitely and FILL_GAP is ignored.

## Test plan
- **Single frame:** reset; req=0001, hdr_type=0, pl_data[7:0] counts 0x01..0x0A.
  - Expect tx_data AA,AF,01..0A; tx_pos 0..11; frame_done at tx_pos 11; then IDLE_BYTE.
- **Round-robin:** req=1111 held, all hdr_type=1.
  - Grants in order 0001,0010,0100,1000,0001, back-to-back with no idle.
  - Every frame starts 55,BA.
- **Mid-frame changes:** drop req and tx_en at tx_pos 5.
  - The frame completes all 12 bytes; no new frame starts; req arriving later with tx_en=0 gets no grant.
- **Reset mid-frame:** assert reset at tx_pos 7.
  - All outputs return to reset values asynchronously; after release, req=0100 is granted first, since the RR pointer resets to 0 and req0 is low.
- **Fill frame (FILL_FRAME_EN):** req=0 for 60 cycles after reset.
  - Fill frame AA,AF + 10×IDLE_BYTE starts after 24 idle bytes, with grant=0.
  - Without the macro, only IDLE_BYTE appears for 60 cycles.
